// File: rtl/sirv_mrom_icb_ctrl.sv
// ICB slave front-end for the mask ROM: forwards the word address to the ROM and
// queues {rdata, err} responses in a 2-entry FIFO so the bus runs at full rate.
module sirv_mrom_icb_ctrl #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_icb_cmd_valid,
  output logic            i_icb_cmd_ready,
  input  logic [31:0]     i_icb_cmd_addr,
  input  logic            i_icb_cmd_read,
  input  logic [DW-1:0]   i_icb_cmd_wdata,
  input  logic [DW/8-1:0] i_icb_cmd_wmask,
  output logic            i_icb_rsp_valid,
  input  logic            i_icb_rsp_ready,
  output logic [DW-1:0]   i_icb_rsp_rdata,
  output logic            i_icb_rsp_err,
  output logic [AW-3:0]   rom_addr,
  input  logic [DW-1:0]   rom_dout,
  output logic            icb_idle
);

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t       fifo_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] count_q;

  logic cmd_fire;
  logic rsp_fire;
  logic cmd_err;
  rsp_t push_entry;

  // Write data/mask and the upper address bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_cmd_addr[31:AW]};

  assign rom_addr = i_icb_cmd_addr[AW-1:2];

  assign i_icb_cmd_ready = (count_q != 2'd2);
  assign i_icb_rsp_valid = (count_q != 2'd0);
  assign icb_idle        = (count_q == 2'd0);

  assign cmd_fire = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rsp_fire = i_icb_rsp_valid & i_icb_rsp_ready;

  // Writes and misaligned reads never use the ROM data.
  assign cmd_err          = ~i_icb_cmd_read | (i_icb_cmd_addr[1:0] != 2'b00);
  assign push_entry.err   = cmd_err;
  assign push_entry.rdata = cmd_err ? '0 : rom_dout;

  assign i_icb_rsp_rdata = fifo_q[rptr_q].rdata;
  assign i_icb_rsp_err   = fifo_q[rptr_q].err;

  // NOTE: the FIFO storage is reset too, so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (cmd_fire) begin
        fifo_q[wptr_q] <= push_entry;
        wptr_q         <= ~wptr_q;
      end
      if (rsp_fire) rptr_q <= ~rptr_q;
      case ({cmd_fire, rsp_fire})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_mrom_icb_ctrl.sv
// Self-checking bench for sirv_mrom_icb_ctrl: a queue-based response model and a
// behavioural ROM drive directed scenarios and a randomized traffic run.
module tb_sirv_mrom_icb_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int WORDS = 1 << (AW - 2);

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_icb_cmd_valid;
  logic            i_icb_cmd_ready;
  logic [31:0]     i_icb_cmd_addr;
  logic            i_icb_cmd_read;
  logic [DW-1:0]   i_icb_cmd_wdata;
  logic [DW/8-1:0] i_icb_cmd_wmask;
  logic            i_icb_rsp_valid;
  logic            i_icb_rsp_ready;
  logic [DW-1:0]   i_icb_rsp_rdata;
  logic            i_icb_rsp_err;
  logic [AW-3:0]   rom_addr;
  logic [DW-1:0]   rom_dout;
  logic            icb_idle;

  logic [DW-1:0] rom [WORDS];
  exp_t          exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_dout = rom[rom_addr];

  sirv_mrom_icb_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (i_icb_cmd_valid),
    .i_icb_cmd_ready (i_icb_cmd_ready),
    .i_icb_cmd_addr  (i_icb_cmd_addr),
    .i_icb_cmd_read  (i_icb_cmd_read),
    .i_icb_cmd_wdata (i_icb_cmd_wdata),
    .i_icb_cmd_wmask (i_icb_cmd_wmask),
    .i_icb_rsp_valid (i_icb_rsp_valid),
    .i_icb_rsp_ready (i_icb_rsp_ready),
    .i_icb_rsp_rdata (i_icb_rsp_rdata),
    .i_icb_rsp_err   (i_icb_rsp_err),
    .rom_addr        (rom_addr),
    .rom_dout        (rom_dout),
    .icb_idle        (icb_idle)
  );

  function automatic exp_t model_rsp(input logic rd, input logic [31:0] a);
    exp_t e;
    e.err   = !rd || (a[1:0] != 2'b00);
    e.rdata = e.err ? '0 : rom[a[AW-1:2]];
    return e;
  endfunction

  // One clock of traffic, entered and left at a negedge; compares against the queue model.
  task automatic step(input logic v, input logic rd, input logic [31:0] a, input logic rr);
    bit   exp_fire, exp_pop;
    logic [AW-3:0] exp_ra;
    i_icb_cmd_valid = v;
    i_icb_cmd_read  = rd;
    i_icb_cmd_addr  = a;
    i_icb_cmd_wdata = $urandom;
    i_icb_cmd_wmask = 4'($urandom);
    i_icb_rsp_ready = rr;
    #1;
    exp_ra = a[AW-1:2];
    n_checks++;
    if (i_icb_cmd_ready !== (exp_q.size() != 2)) begin
      n_fail++;
      $display("FAIL cmd_ready: got %b want %b (depth %0d)", i_icb_cmd_ready, exp_q.size() != 2, exp_q.size());
    end
    n_checks++;
    if (rom_addr !== exp_ra) begin
      n_fail++;
      $display("FAIL rom_addr: got %h want %h", rom_addr, exp_ra);
    end
    exp_fire = v && (exp_q.size() != 2);
    exp_pop  = rr && (exp_q.size() != 0);
    @(posedge clk);
    if (exp_pop) void'(exp_q.pop_front());
    if (exp_fire) exp_q.push_back(model_rsp(rd, a));
    @(negedge clk);
    n_checks++;
    if (i_icb_rsp_valid !== (exp_q.size() != 0) || icb_idle !== (exp_q.size() == 0)) begin
      n_fail++;
      $display("FAIL rsp_valid/idle: got %b/%b want depth %0d", i_icb_rsp_valid, icb_idle, exp_q.size());
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if (i_icb_rsp_rdata !== exp_q[0].rdata || i_icb_rsp_err !== exp_q[0].err) begin
        n_fail++;
        $display("FAIL rsp_head: got %h/%b want %h/%b", i_icb_rsp_rdata, i_icb_rsp_err,
                 exp_q[0].rdata, exp_q[0].err);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (i_icb_cmd_ready !== 1'b1 || i_icb_rsp_valid !== 1'b0 || icb_idle !== 1'b1 ||
        i_icb_rsp_rdata !== '0 || i_icb_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b valid=%b idle=%b rdata=%h err=%b want 1 0 1 0 0", tag,
               i_icb_cmd_ready, i_icb_rsp_valid, icb_idle, i_icb_rsp_rdata, i_icb_rsp_err);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step(1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_icb_cmd_valid = 1'b0; i_icb_cmd_read = 1'b1; i_icb_cmd_addr = '0;
    i_icb_cmd_wdata = '0; i_icb_cmd_wmask = '0; i_icb_rsp_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want [3];
    want[0] = 32'h7ffff297; want[1] = 32'h00028067; want[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'(4 * i), 1'b1);
      n_checks++;
      if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== want[i] || i_icb_rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got %b/%h/%b want 1/%h/0", i, i_icb_rsp_valid,
                 i_icb_rsp_rdata, i_icb_rsp_err, want[i]);
      end
    end
    drain();
  endtask

  task automatic test_errors();
    step(1'b1, 1'b0, 32'h4, 1'b1);
    n_checks++;
    if (i_icb_rsp_err !== 1'b1 || i_icb_rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL write_err: got %h/%b want 0/1", i_icb_rsp_rdata, i_icb_rsp_err);
    end
    step(1'b1, 1'b1, 32'h4, 1'b1);
    n_checks++;
    if (i_icb_rsp_err !== 1'b0 || i_icb_rsp_rdata !== 32'h00028067) begin
      n_fail++;
      $display("FAIL read_after_write: got %h/%b want 00028067/0", i_icb_rsp_rdata, i_icb_rsp_err);
    end
    step(1'b1, 1'b1, 32'h2, 1'b1);
    n_checks++;
    if (i_icb_rsp_err !== 1'b1 || i_icb_rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL misaligned_err: got %h/%b want 0/1", i_icb_rsp_rdata, i_icb_rsp_err);
    end
    step(1'b1, 1'b1, 32'h0, 1'b1);
    n_checks++;
    if (i_icb_rsp_err !== 1'b0 || i_icb_rsp_rdata !== 32'h7ffff297) begin
      n_fail++;
      $display("FAIL read_after_misaligned: got %h/%b want 7ffff297/0", i_icb_rsp_rdata, i_icb_rsp_err);
    end
    drain();
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h4, 1'b0);
    step(1'b1, 1'b1, 32'h8, 1'b0);  // offered while full, must not be taken
    n_checks++;
    if (i_icb_cmd_ready !== 1'b0 || icb_idle !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got ready=%b idle=%b want 0 0", i_icb_cmd_ready, icb_idle);
    end
    step(1'b1, 1'b1, 32'h8, 1'b1);  // pop 0x0, still full this cycle
    n_checks++;
    if (i_icb_rsp_rdata !== 32'h00028067) begin
      n_fail++;
      $display("FAIL bp_second: got %h want 00028067", i_icb_rsp_rdata);
    end
    step(1'b1, 1'b1, 32'h8, 1'b1);  // pop 0x4, accept 0x8
    n_checks++;
    if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== 32'h0 || i_icb_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_third: got %b/%h/%b want 1/0/0", i_icb_rsp_valid, i_icb_rsp_rdata, i_icb_rsp_err);
    end
    drain();
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b1, 32'h4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'((i % 3) * 4), 1'b1);
      n_checks++;
      if (exp_q.size() != 1 || icb_idle !== 1'b0 || i_icb_cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL push_pop%0d: got idle=%b ready=%b want 0 1 at depth 1", i, icb_idle, i_icb_cmd_ready);
      end
    end
    drain();
  endtask

  task automatic test_reset_when_full();
    step(1'b1, 1'b1, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_values("reset_when_full");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 32'h4, 1'b1);
    n_checks++;
    if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== 32'h00028067 || i_icb_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_read: got %b/%h/%b want 1/00028067/0", i_icb_rsp_valid,
               i_icb_rsp_rdata, i_icb_rsp_err);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 8) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a[AW-1:4] = '0;  // favour the known words
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
    rom[0] = 32'h7ffff297;
    rom[1] = 32'h00028067;
    rom[2] = 32'h00000000;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_push_pop();
    test_reset_when_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sirv_mrom_icb_ctrl.md
# sirv_mrom_icb_ctrl

ICB slave front-end for the mask ROM (`sirv_mrom`) in the Nuclei SoC. It accepts ICB commands, drives the ROM word address, and captures the combinational ROM output into a 2-entry response FIFO. It returns in-order responses with full throughput and backpressure tolerance. Writes and misaligned accesses return a bus error without touching the ROM.

## Interface
Parameters:
- `AW`, default 12: ROM byte-address width; matches the ROM's `AW`.
- `DW`, default 32: data width; matches the ROM's `DW`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `i_icb_cmd_valid`, in, 1: command valid.
- `i_icb_cmd_ready`, out, 1: command ready.
- `i_icb_cmd_addr`, in, 32: byte address. Bits [31:AW] are ignored; region decode happens upstream.
- `i_icb_cmd_read`, in, 1: 1 = read, 0 = write.
- `i_icb_cmd_wdata`, in, DW: write data, ignored.
- `i_icb_cmd_wmask`, in, DW/8: write mask, ignored.
- `i_icb_rsp_valid`, out, 1: response valid.
- `i_icb_rsp_ready`, in, 1: response ready.
- `i_icb_rsp_rdata`, out, DW: read data.
- `i_icb_rsp_err`, out, 1: error response.
- `rom_addr`, out, AW-2: ROM word address. Connects to `sirv_mrom.rom_addr`.
- `rom_dout`, in, DW: ROM data. Combinational from `rom_addr`.
- `icb_idle`, out, 1: high when the response FIFO is empty.

## Operation
- Handshakes:
  - Command handshake: `cmd_fire = i_icb_cmd_valid & i_icb_cmd_ready`.
  - Response handshake: `rsp_fire = i_icb_rsp_valid & i_icb_rsp_ready`.
- `rom_addr = i_icb_cmd_addr[AW-1:2]`, driven combinationally at all times, independent of valid.
- Error condition: `err = ~i_icb_cmd_read | (i_icb_cmd_addr[1:0] != 2'b00)`.
- On `cmd_fire`, push the entry {rdata, err}:
  - rdata = `err ? 0 : rom_dout`.
  - No state other than the FIFO is modified.
- Response FIFO:
  - 2 entries, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
  - `i_icb_cmd_ready = (count != 2)`. There is no combinational path from `rsp_ready` to `cmd_ready`.
  - `i_icb_rsp_valid = (count != 0)`.
  - `i_icb_rsp_rdata` and `i_icb_rsp_err` are always the head entry (entry at the read pointer).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap 1→0.
- Responses are strictly in command order, with exactly one response per accepted command.
- `icb_idle = (count == 0)`.

## Timing
- Reset (async assert, sync-release assumed upstream):
  - count=0, both pointers=0, both entries' rdata=0 and err=0.
  - Hence `i_icb_cmd_ready`=1, `i_icb_rsp_valid`=0, `i_icb_rsp_rdata`=0, `i_icb_rsp_err`=0, `icb_idle`=1.
- Latency: a command accepted in cycle N gives `i_icb_rsp_valid`=1 in cycle N+1 if the FIFO was empty.
- Throughput: with `rsp_ready` held high, one command is accepted every cycle indefinitely; count oscillates 0→1 and stays at 1.
- Full (count=2): `cmd_ready`=0 in the same cycle count reaches 2. A pop in that cycle raises `cmd_ready` the next cycle.
- Empty: `rsp_ready` with count=0 has no effect; pointers do not move.
- Reset asserted mid-transaction:
  - All pending responses are discarded immediately.
  - Outputs take reset values asynchronously.
  - No response is produced for commands accepted before reset.
- `rom_dout` is sampled only in the `cmd_fire` cycle. Changes in `rom_addr` while not firing are don't-care.

## Test plan
- Reset, then read 0x0, 0x4, 0x8 back-to-back with rsp_ready=1:
  - rdata = 0x7ffff297, 0x00028067, 0x00000000 in cycles N+1, N+2, N+3.
  - err=0 for all three.
- Write to 0x4 with wdata=0xDEADBEEF:
  - One response with err=1, rdata=0.
  - A following read of 0x4 returns 0x00028067, err=0.
- Misaligned read at 0x2:
  - err=1, rdata=0.
  - The next read at 0x0 returns 0x7ffff297, err=0.
- Backpressure, rsp_ready=0, three reads offered (0x0, 0x4, 0x8):
  - The first two are accepted; `cmd_ready`=0 on the third; `icb_idle`=0.
  - Raise rsp_ready: responses arrive as 0x7ffff297, then 0x00028067, then the third command is accepted and returns 0.
- Simultaneous push/pop at count=1: count stays 1, pointers wrap correctly across 4 consecutive transactions, and the data order is preserved.
- Assert rst_n low with count=2:
  - `rsp_valid`=0 immediately and `cmd_ready`=1.
  - After release, a read of 0x4 returns 0x00028067 with one-cycle latency.
